// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// A byte leaves the FIFO when its frame starts, so fifo_count never includes
// the byte in the shifter. A STOP bit that ends with data queued rolls
// straight into the next START bit, so frames can run back to back.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 5,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state;
  logic [15:0]    bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  logic           push;
  logic           pop;
  logic           bit_last;
  logic           frame_next;
  logic [CW-1:0]  count_next;

  // Ready is held high through reset; the reset itself blocks the write.
  assign in_ready   = rst || (fifo_count != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready && !rst;
  assign bit_last   = (bit_cnt == 16'(CLK_PER_BIT - 1));
  // Pop when idle, or on the final cycle of a stop bit, provided data waits.
  assign pop        = (fifo_count != '0) &&
                      ((state == IDLE) || ((state == STOP) && bit_last));
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  // Whether a frame will be on the line after the coming edge.
  always_comb begin
    frame_next = 1'b1;
    case (state)
      IDLE:    frame_next = pop;
      STOP:    frame_next = !bit_last || pop;
      default: frame_next = 1'b1;
    endcase
  end

  // FIFO storage; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers, occupancy and busy; pointers wrap on their natural width.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_next;
      busy       <= frame_next || (count_next != '0);
    end
  end

  // Transmit FSM: START, 8 data bits LSB first, STOP; txd is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd     <= 1'b1;
          bit_cnt <= '0;
          bit_idx <= '0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              txd   <= 1'b0;
              state <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-frame-offset model checked every cycle,
// a mid-bit line decoder, and directed scenarios with literal expectations.
module tb_uart_tx_fifo;
  localparam int CPB   = 5;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, txd, busy;
  logic [4:0] fifo_count;

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .txd(txd), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: queued bytes plus the frame on the line, tracked as a cycle offset.
  logic [7:0] m_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_log[$];
  bit         m_active = 1'b0;
  int         m_off = 0;
  logic [7:0] m_byte = 8'h00;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      if (m_active && m_off < 9 * CPB + CPB / 2) void'(exp_rx.pop_back());
      m_q.delete();
      m_active = 1'b0;
      m_off    = 0;
    end else begin
      bit do_pop, do_push;
      do_pop  = (m_q.size() > 0) && (!m_active || m_off == FRAME - 1);
      do_push = in_valid && (m_q.size() < DEPTH);
      if (m_active) begin
        if (m_off == FRAME - 1) m_active = 1'b0;
        else m_off++;
      end
      if (do_pop) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_off    = 0;
        exp_rx.push_back(m_byte);
      end
      if (do_push) m_q.push_back(in_data);
    end
  end

  function automatic logic exp_txd();
    int bi;
    if (!m_active) return 1'b1;
    bi = m_off / CPB;
    if (bi == 0) return 1'b0;
    if (bi >= 9) return 1'b1;
    return m_byte[bi-1];
  endfunction

  // Every-cycle comparison against the model.
  initial forever begin
    @(posedge clk); #2;
    if (chk_en) begin
      chk("mon_txd", txd, exp_txd());
      chk("mon_busy", busy, m_active || (m_q.size() != 0));
      chk("mon_count", fifo_count, m_q.size());
      chk("mon_in_ready", in_ready, rst || (m_q.size() != DEPTH));
    end
  end

  // Line decoder: samples each bit at its middle; a reset abandons the frame.
  initial begin
    int s_off;
    logic [7:0] s_b;
    s_off = -1;
    s_b   = 8'h00;
    forever begin
      @(posedge clk); #3;
      if (rst) s_off = -1;
      else if (s_off < 0) begin
        if (chk_en && txd === 1'b0) s_off = 0;
      end else s_off++;
      if (s_off >= 0) begin
        if (s_off == CPB / 2) chk("rx_start_bit", txd, 1'b0);
        for (int k = 0; k < 8; k++)
          if (s_off == (k + 1) * CPB + CPB / 2) s_b[k] = txd;
        if (s_off == 9 * CPB + CPB / 2) begin
          chk("rx_stop_bit", txd, 1'b1);
          rx_log.push_back(s_b);
          if (exp_rx.size() == 0) chk("rx_unexpected_frame", 1, 0);
          else chk("rx_order", s_b, exp_rx.pop_front());
          s_off = -1;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic push_byte(input logic [7:0] b);
    int t;
    logic acc;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      t++;
    end while (!acc && t < 4000);
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t;
    t = 0;
    while (busy && t < budget) begin @(negedge clk); t++; end
    chk(name, busy, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    logic [7:0] src[$];
    int b, t;

    // Reset state, including ready asserted during reset.
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Single 0xA8: start, 0,0,0,1,0,1,0,1, stop, each held CPB cycles.
    pat = 10'b11_0101_0000;
    push_byte(8'hA8);
    in_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      @(posedge clk); #2;
      chk("single_txd", txd, pat[k / CPB]);
    end
    @(posedge clk); #2;
    chk("single_end_txd", txd, 1'b1);
    chk("single_end_busy", busy, 1'b0);
    @(negedge clk);

    // Back to back: 4 frames, busy solid for 200 cycles, then idle.
    push_byte(8'hA8);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    in_valid = 1'b0;
    chk("b2b_count", fifo_count, 3);
    for (int k = 0; k < 4 * FRAME - 3; k++) begin
      @(posedge clk); #2;
      chk("b2b_busy", busy, 1'b1);
    end
    @(posedge clk); #2;
    chk("b2b_end_busy", busy, 1'b0);
    chk("b2b_end_txd", txd, 1'b1);
    @(negedge clk);

    // Fill: one byte sits in the shifter, 16 queue, so 0x00..0x10 are taken.
    rx_log.delete();
    b = 0;
    t = 0;
    in_valid = 1'b1;
    while (in_ready && t < 200) begin
      in_data = 8'(b);
      @(posedge clk);
      b++;
      @(negedge clk);
      t++;
    end
    chk("full_count", fifo_count, 16);
    chk("full_accepted", b, 17);
    in_data = 8'(b);
    repeat (20) @(negedge clk);
    chk("blocked_count", fifo_count, 16);
    chk("blocked_in_ready", in_ready, 1'b0);
    // Stop end pops to 15; the held byte then enters on the next edge.
    t = 0;
    while (!in_ready && t < 2 * FRAME) begin @(negedge clk); t++; end
    chk("refill_ready", in_ready, 1'b1);
    chk("refill_count_before", fifo_count, 15);
    @(negedge clk);
    chk("refill_count_after", fifo_count, 16);
    in_valid = 1'b0;
    wait_idle(25 * FRAME, "full_drain");
    repeat (2) @(negedge clk);
    chk("full_rx_len", rx_log.size(), 18);
    for (int i = 0; i < rx_log.size() && i < 18; i++) chk("full_rx_byte", rx_log[i], i);

    // Reset during data bit 3 of 0x15 with 2 bytes queued.
    push_byte(8'h15);
    push_byte(8'hAA);
    push_byte(8'hBB);
    in_valid = 1'b0;
    chk("rstmid_count", fifo_count, 2);
    repeat (19) @(posedge clk);
    #2;
    chk("rstmid_bit3", txd, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #2;
    chk("rstmid_txd", txd, 1'b1);
    chk("rstmid_count0", fifo_count, 0);
    chk("rstmid_busy", busy, 1'b0);
    @(negedge clk) rst = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    chk("rstmid_quiet_txd", txd, 1'b1);
    chk("rstmid_quiet_busy", busy, 1'b0);
    @(negedge clk);

    // Stream: length header 168 LE, then 168 payload bytes.
    rx_log.delete();
    src.push_back(8'hA8);
    src.push_back(8'h00);
    src.push_back(8'h00);
    src.push_back(8'h00);
    for (int i = 0; i < 168; i++) src.push_back(8'((i * 37 + 11) & 255));
    foreach (src[i]) push_byte(src[i]);
    in_valid = 1'b0;
    wait_idle(200 * FRAME, "stream_drain");
    repeat (5) @(negedge clk);
    chk("stream_rx_len", rx_log.size(), 172);
    for (int i = 0; i < rx_log.size() && i < 172; i++) chk("stream_rx_byte", rx_log[i], src[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
